axil_reg_arbiter: RTL and testbench

//  Round-robin arbiter and AXI4-Lite master sequencer: two simple requesters (core-side, debug/boot config) share one AXI4-Lite register slave (UART CSR block).
//  One transaction in flight; each grant is fully sequenced through AW/W/B or AR/R before the next grant. Byte-wide register data.

---
 rtl/axil_reg_arbiter.sv | 131 +++++++++++++
 tb/tb_axil_reg_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_arbiter.sv
// Round-robin arbiter for two register requesters sharing one AXI4-Lite slave.
// One transaction in flight, fully sequenced through AW/W/B or AR/R before the next grant.
module axil_reg_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]             req_wdata,
    output logic [1:0]              req_done,
    output logic [7:0]              rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [3:0]              wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready
);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

    state_t                state;
    logic                  rr;
    logic                  gnt;
    logic                  pick;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]            sel_byte;

    // Both requesting: the one that did not win last time goes next.
    always_comb begin
        pick     = (req_valid == 2'b11) ? ~rr : req_valid[1];
        sel_we   = pick ? req_we[1] : req_we[0];
        sel_addr = pick ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
        sel_byte = pick ? req_wdata[15:8] : req_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= 1'b0;
            gnt       <= 1'b0;
            req_done  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        gnt <= pick;
                        rr  <= pick;
                        if (sel_we) begin
                            awaddr  <= sel_addr;
                            wdata   <= {{(DATA_WIDTH-8){1'b0}}, sel_byte};
                            wstrb   <= 4'b0001;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_ADDR;
                        end else begin
                            araddr  <= sel_addr;
                            arvalid <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    // A channel whose valid already dropped has completed its handshake.
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready        <= 1'b0;
                        rsp_err       <= (bresp != 2'b00);
                        rsp_rdata     <= '0;
                        req_done[gnt] <= 1'b1;
                        state         <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready        <= 1'b0;
                        rsp_rdata     <= rdata[7:0];
                        rsp_err       <= (rresp != 2'b00);
                        req_done[gnt] <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Directed bench for axil_reg_arbiter with a delay-configurable AXI4-Lite slave.
module tb_axil_reg_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid, req_we;
    logic [2*AW-1:0] req_addr;
    logic [15:0]   req_wdata;
    logic [1:0]    req_done;
    logic [7:0]    rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axil_reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // Slave: each ready/response fires after a configurable number of wait cycles.
    int   aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic r_force = 1'b0;
    logic [1:0] s_bresp = 2'b00, s_rresp = 2'b00;
    logic [DW-1:0] s_rdata = '0;

    assign awready = awvalid && (aw_cnt == aw_dly);
    assign wready  = wvalid  && (w_cnt == w_dly);
    assign bvalid  = bready  && (b_cnt == b_dly);
    assign arready = arvalid && (ar_cnt == ar_dly);
    assign rvalid  = (rready && (r_cnt == r_dly)) || r_force;
    assign bresp   = s_bresp;
    assign rresp   = s_rresp;
    assign rdata   = s_rdata;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid  && !wready)  ? w_cnt + 1  : 0;
            b_cnt  <= (bready  && !bvalid)  ? b_cnt + 1  : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            r_cnt  <= (rready  && !rvalid)  ? r_cnt + 1  : 0;
        end
    end

    // Cumulative observation counters; tests take differences.
    int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_wait = 0, overlap = 0;
    logic [AW-1:0] cap_awaddr = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic [3:0]    cap_wstrb = '0;

    always @(posedge clk) begin
        if (awvalid) aw_cyc <= aw_cyc + 1;
        if (wvalid)  w_cyc  <= w_cyc + 1;
        if (arvalid) ar_cyc <= ar_cyc + 1;
        if (bready && !bvalid) b_wait <= b_wait + 1;
        if ((awvalid || wvalid || bready) && (arvalid || rready)) overlap <= overlap + 1;
        if (req_done == 2'b11) overlap <= overlap + 1;
        if (awvalid && awready) cap_awaddr <= awaddr;
        if (wvalid && wready) begin
            cap_wdata <= wdata;
            cap_wstrb <= wstrb;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (req_done == 2'b00 && lat < 40);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int lat;
    int a0, w0, ar0, bw0;
    logic [5:0] grants;
    logic [5:0] exp_grants;

    initial begin
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        @(posedge clk); #1;
        do_reset();

        check("rst_awvalid", {31'b0, awvalid}, 32'd0);
        check("rst_arvalid", {31'b0, arvalid}, 32'd0);
        check("rst_req_done", {30'b0, req_done}, 32'd0);
        check("rst_bready_rready", {30'b0, bready, rready}, 32'd0);

        // Single write from requester 0, zero-wait slave.
        a0 = aw_cyc;
        req_valid = 2'b01; req_we = 2'b01; req_addr = 8'h04; req_wdata = 16'h00A5;
        wait_done(lat);
        check("wr_latency", lat, 32'd3);
        check("wr_done", {30'b0, req_done}, 32'd1);
        check("wr_err", {31'b0, rsp_err}, 32'd0);
        check("wr_rdata", {24'b0, rsp_rdata}, 32'd0);
        check("wr_awaddr", {28'b0, cap_awaddr}, 32'd4);
        check("wr_wdata", cap_wdata, 32'h000000A5);
        check("wr_wstrb", {28'b0, cap_wstrb}, 32'd1);
        check("wr_aw_cycles", aw_cyc - a0, 32'd1);
        tick();
        req_valid = 2'b00;
        check("wr_done_one_cycle", {30'b0, req_done}, 32'd0);

        // Single read from requester 1, arready after two wait cycles.
        ar_dly = 2; s_rdata = 32'hDEAD005A;
        ar0 = ar_cyc;
        req_valid = 2'b10; req_we = 2'b00; req_addr = 8'h80;
        wait_done(lat);
        check("rd_latency", lat, 32'd5);
        check("rd_done", {30'b0, req_done}, 32'd2);
        check("rd_rdata", {24'b0, rsp_rdata}, 32'h5A);
        check("rd_err", {31'b0, rsp_err}, 32'd0);
        check("rd_ar_cycles", ar_cyc - ar0, 32'd3);
        tick();
        req_valid = 2'b00;
        ar_dly = 0;

        // Both requesting continuously: grants alternate starting with requester 1.
        do_reset();
        req_valid = 2'b11; req_we = 2'b01; req_addr = 8'h21; req_wdata = 16'h0011;
        exp_grants = 6'b010101;
        grants = '0;
        for (int i = 0; i < 6; i++) begin
            wait_done(lat);
            grants[i] = req_done[1];
            check("rr_done_valid", {31'b0, ^req_done}, 32'd1);
        end
        check("rr_grant_seq", {26'b0, grants}, {26'b0, exp_grants});
        check("rr_no_overlap", overlap, 32'd0);
        tick();
        req_valid = 2'b00;

        // Staggered AW/W handshakes, one B wait cycle, SLVERR response.
        aw_dly = 0; w_dly = 2; b_dly = 1; s_bresp = 2'b10;
        a0 = aw_cyc; w0 = w_cyc; bw0 = b_wait;
        req_valid = 2'b01; req_we = 2'b01; req_addr = 8'h03; req_wdata = 16'h0077;
        wait_done(lat);
        check("stag_aw_cycles", aw_cyc - a0, 32'd1);
        check("stag_w_cycles", w_cyc - w0, 32'd3);
        check("stag_b_wait", b_wait - bw0, 32'd1);
        check("stag_err", {31'b0, rsp_err}, 32'd1);
        check("stag_latency", lat, 32'd6);
        tick();
        req_valid = 2'b00;
        w_dly = 0; b_dly = 0; s_bresp = 2'b00;

        // Reset while waiting in RD_DATA.
        r_dly = 8;
        req_valid = 2'b10; req_we = 2'b00; req_addr = 8'h50;
        lat = 0;
        while (!rready && lat < 20) begin
            tick();
            lat++;
        end
        check("rst_mid_reached_rd_data", {31'b0, rready}, 32'd1);
        rst = 1'b1;
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        check("rst_mid_outputs", {28'b0, arvalid, rready, req_done}, 32'd0);
        r_force = 1'b1;
        tick();
        tick();
        check("rst_mid_stray_rvalid", {29'b0, rready, req_done}, 32'd0);
        r_force = 1'b0;
        r_dly = 0;
        req_valid = 2'b01; req_we = 2'b01; req_addr = 8'h06; req_wdata = 16'h0033;
        wait_done(lat);
        check("rst_next_req0_done", {30'b0, req_done}, 32'd1);
        check("rst_next_latency", lat, 32'd3);
        tick();
        req_valid = 2'b00;
        check("final_overlap", overlap, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
